// File: rtl/load_write_queue.sv
// Write-buffer between a byte loader and memory: a circular FIFO of {addr, data}
// entries drained one write at a time through a req/ack handshake.
module load_write_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 22
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          in_addr,
    input  logic [7:0]             in_data,
    input  logic                   in_write,
    input  logic                   in_done,
    output logic [AW-1:0]          mem_addr,
    output logic [7:0]             mem_data,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic                   load_complete,
    output logic                   state_dbg
);
    // Handshake: mem_req/mem_addr/mem_data hold steady until mem_ack is sampled
    // high on a rising edge; that edge retires the presented entry.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 8;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     buf_q [DEPTH];
    logic [EW-1:0]     buf_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rd_next;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_req_q, mem_req_d;
    logic              overflow_q, overflow_d;
    logic              done_seen_q, done_seen_d;
    logic              load_complete_q, load_complete_d;
    logic              full_w;
    logic              push;
    logic              pop;

    assign full_w  = (count_q == CW'(DEPTH));
    assign push    = in_write && !full_w;
    assign pop     = (state_q == REQ) && mem_ack;
    assign rd_next = rd_ptr_q + PW'(1);

    always_comb begin
        state_d         = state_q;
        buf_d           = buf_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        overflow_d      = overflow_q;
        done_seen_d     = done_seen_q | in_done;
        load_complete_d = load_complete_q |
                          (done_seen_q && (count_q == '0) && (state_q == IDLE));

        if (in_write && full_w) overflow_d = 1'b1;
        if (push) begin
            buf_d[wr_ptr_q] = {in_addr, in_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_next;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A byte pushed into an empty queue bypasses storage so it is presented next cycle.
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d                  = REQ;
                    {mem_addr_d, mem_data_d} = buf_q[rd_ptr_q];
                end else if (push) begin
                    state_d                  = REQ;
                    {mem_addr_d, mem_data_d} = {in_addr, in_data};
                end
            end
            REQ: begin
                if (pop) begin
                    if (count_q > CW'(1)) begin
                        {mem_addr_d, mem_data_d} = buf_q[rd_next];
                    end else if (push) begin
                        {mem_addr_d, mem_data_d} = {in_addr, in_data};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            mem_req_q       <= 1'b0;
            overflow_q      <= 1'b0;
            done_seen_q     <= 1'b0;
            load_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            mem_req_q       <= mem_req_d;
            overflow_q      <= overflow_d;
            done_seen_q     <= done_seen_d;
            load_complete_q <= load_complete_d;
        end
        buf_q <= buf_d;
    end

    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign mem_req       = mem_req_q;
    assign count         = count_q;
    assign full          = full_w;
    assign overflow      = overflow_q;
    assign load_complete = load_complete_q;
    assign state_dbg     = (state_q == REQ);

endmodule

// File: tb/tb_load_write_queue.sv
// Directed bench for load_write_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_load_write_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 22;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [AW-1:0] in_addr;
    logic [7:0]    in_data;
    logic          in_write;
    logic          in_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_req;
    logic          mem_ack;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          load_complete;
    logic          state_dbg;

    int checks = 0;
    int errors = 0;

    load_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_addr(in_addr), .in_data(in_data), .in_write(in_write), .in_done(in_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_req(mem_req), .mem_ack(mem_ack),
        .count(count), .full(full), .overflow(overflow),
        .load_complete(load_complete), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: exp_q holds every unacknowledged entry, head is presented
    logic [AW+7:0] exp_q[$];
    logic          m_valid = 1'b0;
    logic          m_req, m_ovf, m_done, m_lc;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;

    always @(posedge clk) begin
        int  old_size;
        logic old_req, old_done;
        if (reset) begin
            exp_q.delete();
            m_req = 0; m_ovf = 0; m_done = 0; m_lc = 0;
            m_addr = '0; m_data = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            old_size = exp_q.size();
            old_req  = m_req;
            old_done = m_done;
            if (m_req && mem_ack) void'(exp_q.pop_front());
            if (in_write) begin
                if (old_size < DEPTH) exp_q.push_back({in_addr, in_data});
                else m_ovf = 1'b1;
            end
            m_done = m_done | in_done;
            if (old_done && old_size == 0 && !old_req) m_lc = 1'b1;
            m_req = (exp_q.size() > 0);
            if (m_req) {m_addr, m_data} = exp_q[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_req", 32'(mem_req), 32'(m_req));
            check("cmp_count", 32'(count), 32'(exp_q.size()));
            check("cmp_full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("cmp_overflow", 32'(overflow), 32'(m_ovf));
            check("cmp_load_complete", 32'(load_complete), 32'(m_lc));
            if (m_req) begin
                check("cmp_addr", 32'(mem_addr), 32'(m_addr));
                check("cmp_data", 32'(mem_data), 32'(m_data));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        in_addr  = a;
        in_data  = d;
        in_write = 1'b1;
        tick();
        in_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_addr = '0; in_data = '0; in_write = 0; in_done = 0; mem_ack = 0;
        tick(); tick();
        check("rst_count", 32'(count), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_full", 32'(full), 0);
        check("rst_lc", 32'(load_complete), 0);
        reset = 1'b0;

        // single write with ack held high
        mem_ack = 1'b1;
        push(22'h000010, 8'hA5);
        check("single_req", 32'(mem_req), 1);
        check("single_addr", 32'(mem_addr), 32'h10);
        check("single_data", 32'(mem_data), 32'hA5);
        check("single_count1", 32'(count), 1);
        tick();
        check("single_count0", 32'(count), 0);
        check("single_idle", 32'(mem_req), 0);

        // stall then drain in order
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) push(AW'(32'h100 + i), 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            check("stall_count", 32'(count), 3);
            check("stall_addr", 32'(mem_addr), 32'h100);
            check("stall_data", 32'(mem_data), 32'h10);
            tick();
        end
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_addr", 32'(mem_addr), 32'h100 + i);
            check("drain_data", 32'(mem_data), 32'h10 + i);
            tick();
        end
        mem_ack = 1'b0;
        check("drain_count", 32'(count), 0);

        // overflow: ninth push dropped
        for (int i = 0; i < 9; i++) begin
            push(AW'(32'h200 + i), 8'(8'h40 + i));
            if (i == 7) begin
                check("ovf_full8", 32'(full), 1);
                check("ovf_not_yet", 32'(overflow), 0);
            end
        end
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_data", 32'(mem_data), 32'h40 + i);
            tick();
        end
        mem_ack = 1'b0;
        check("ovf_empty", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // simultaneous push/pop at count 4, pointers wrap
        for (int i = 0; i < 4; i++) push(AW'(32'h300 + i), 8'(i));
        check("simul_start", 32'(count), 4);
        mem_ack  = 1'b1;
        in_write = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_addr = AW'(32'h310 + k);
            in_data = 8'(8'h80 + k);
            check("simul_count", 32'(count), 4);
            check("simul_addr", 32'(mem_addr), (k < 4) ? 32'h300 + k : 32'h310 + k - 4);
            tick();
        end
        in_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("simul_tail", 32'(mem_addr), 32'h310 + 16 + k);
            tick();
        end
        mem_ack = 1'b0;
        check("simul_empty", 32'(count), 0);

        // completion
        push(22'h400, 8'h01);
        push(22'h401, 8'h02);
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        check("done_pending", 32'(load_complete), 0);
        mem_ack = 1'b1;
        tick();
        check("done_one_left", 32'(load_complete), 0);
        tick();
        check("done_drained", 32'(count), 0);
        check("done_not_yet", 32'(load_complete), 0);
        tick();
        check("done_set", 32'(load_complete), 1);
        mem_ack = 1'b0;
        push(22'h410, 8'h03);
        check("done_late_req", 32'(mem_req), 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("done_sticky", 32'(load_complete), 1);

        // reset mid-request, with push and ack during the reset cycle
        push(22'h500, 8'h55);
        push(22'h501, 8'h56);
        check("rmid_req", 32'(mem_req), 1);
        reset = 1'b1; in_write = 1'b1; in_addr = 22'h5FF; mem_ack = 1'b1;
        tick();
        reset = 1'b0; in_write = 1'b0; mem_ack = 1'b0;
        check("rmid_req0", 32'(mem_req), 0);
        check("rmid_count", 32'(count), 0);
        check("rmid_ovf", 32'(overflow), 0);
        check("rmid_lc", 32'(load_complete), 0);
        push(22'h600, 8'h66);
        check("post_rst_addr", 32'(mem_addr), 32'h600);
        check("post_rst_count", 32'(count), 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("post_rst_empty", 32'(count), 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
